// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: forward select codes, FSM states and
// configuration limits shared by the hazard controller.
package hazard_ctrl_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam int LOAD_LAT_MAX = 2;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_LOAD_WAIT = 2'd1,
    ST_MEM_WAIT  = 2'd2
  } hz_state_e;

  function automatic logic [1:0] fwd_pick(
    input logic m_hit,
    input logic w_hit
  );
    if (m_hit)      return FWD_M;
    else if (w_hit) return FWD_W;
    else            return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// hazard_ctrl_fwd_sel: forward select for one E-stage source.
// M beats W; x0 never forwards.
module hazard_ctrl_fwd_sel
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_i,
  input  logic [REG_AW-1:0] rd_m_i,
  input  logic [REG_AW-1:0] rd_w_i,
  input  logic              we_m_i,
  input  logic              we_w_i,
  input  logic              m_blk_i,
  output logic [1:0]        fwd_o
);

  logic nz;
  logic m_hit;
  logic w_hit;

  assign nz    = (rs_i != '0);
  assign m_hit = nz && (rs_i == rd_m_i) && we_m_i && !m_blk_i;
  assign w_hit = nz && (rs_i == rd_w_i) && we_w_i;
  assign fwd_o = fwd_pick(m_hit, w_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forward control for the 5-stage RV32 core.
// Optional perf counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = 1
`ifdef HAZARD_PERF_CNT_EN
  ,
  parameter int CNT_W    = 32
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*REG_AW-1:0] rs_d_i,
  input  logic [NUM_SRC*REG_AW-1:0] rs_e_i,
  input  logic [REG_AW-1:0]         rd_e_i,
  input  logic [REG_AW-1:0]         rd_m_i,
  input  logic [REG_AW-1:0]         rd_w_i,
  input  logic                      we_reg_file_m_i,
  input  logic                      we_reg_file_w_i,
  input  logic                      result_src_e_0_i,
  input  logic                      pc_src_e_i,
  input  logic                      dmem_req_i,
  input  logic                      dmem_ready_i,
  output logic                      stall_f_o,
  output logic                      stall_d_o,
  output logic                      stall_e_o,
  output logic                      stall_m_o,
  output logic                      flush_d_o,
  output logic                      flush_e_o,
  output logic                      flush_w_o,
  output logic [NUM_SRC*2-1:0]      forward_e_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]          stall_cycles_o,
  output logic [CNT_W-1:0]          flush_events_o,
  output logic [CNT_W-1:0]          mem_wait_cycles_o
`endif
);

  localparam bit Lat2 = (LOAD_LAT == LOAD_LAT_MAX);

  hz_state_e state_q, state_d;
  logic      load_m_q, load_m_d;
  logic      mem_wait;
  logic      lu_hit;
  logic [NUM_SRC*2-1:0] fwd_raw;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_fwd
    hazard_ctrl_fwd_sel #(
      .REG_AW (REG_AW)
    ) u_fwd (
      .rs_i    (rs_e_i[k*REG_AW +: REG_AW]),
      .rd_m_i  (rd_m_i),
      .rd_w_i  (rd_w_i),
      .we_m_i  (we_reg_file_m_i),
      .we_w_i  (we_reg_file_w_i),
      .m_blk_i (Lat2 && load_m_q),
      .fwd_o   (fwd_raw[2*k +: 2])
    );
  end

  assign forward_e_o = rst ? {NUM_SRC{FWD_RF}} : fwd_raw;

  always_comb begin
    lu_hit = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (rs_d_i[k*REG_AW +: REG_AW] == rd_e_i) lu_hit = 1'b1;
    end
    lu_hit = lu_hit && result_src_e_0_i && (rd_e_i != '0);
  end

  // In MEM_WAIT the request is already committed; only ready matters.
  assign mem_wait = (state_q == ST_MEM_WAIT) ? !dmem_ready_i
                                             : (dmem_req_i && !dmem_ready_i);

  always_comb begin
    stall_f_o = 1'b0;
    stall_d_o = 1'b0;
    stall_e_o = 1'b0;
    stall_m_o = 1'b0;
    flush_d_o = 1'b0;
    flush_e_o = 1'b0;
    flush_w_o = 1'b0;
    state_d   = ST_RUN;
    if (rst) begin
      flush_d_o = 1'b1;
      flush_e_o = 1'b1;
      flush_w_o = 1'b1;
    end else if (mem_wait) begin
      stall_f_o = 1'b1;
      stall_d_o = 1'b1;
      stall_e_o = 1'b1;
      stall_m_o = 1'b1;
      flush_w_o = 1'b1;
      state_d   = ST_MEM_WAIT;
    end else if (state_q == ST_LOAD_WAIT) begin
      stall_f_o = 1'b1;
      stall_d_o = 1'b1;
      flush_e_o = 1'b1;
    end else if (lu_hit) begin
      stall_f_o = 1'b1;
      stall_d_o = 1'b1;
      flush_e_o = 1'b1;
      state_d   = Lat2 ? ST_LOAD_WAIT : ST_RUN;
    end else if (pc_src_e_i) begin
      flush_d_o = 1'b1;
      flush_e_o = 1'b1;
    end
  end

  assign load_m_d = stall_m_o ? load_m_q : result_src_e_0_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      load_m_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      load_m_q <= load_m_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] memw_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      memw_cnt_q  <= '0;
    end else begin
      if (stall_f_o && !(&stall_cnt_q))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_e_o && !(&flush_cnt_q))
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      if (stall_m_o && !(&memw_cnt_q))
        memw_cnt_q <= memw_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cycles_o    = stall_cnt_q;
  assign flush_events_o    = flush_cnt_q;
  assign mem_wait_cycles_o = memw_cnt_q;
`endif

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised pipeline hazard controller for the five-stage RV32 core; the successor to the fixed two-source hazard unit. Generates per-stage stall/flush and per-source forwarding selects for NUM_SRC source operands. Adds a load-latency wait state machine for LOAD_LAT up to 2 and a data-memory wait-state handshake that freezes F through M. Sits between the data path and control unit at core top level, fed by stage register addresses and control bits.

## Interface
- REG_AW, 5: register address width
- NUM_SRC, 2: source operands per instruction (2 or 3)
- LOAD_LAT, 1: load-use bubbles (1 or 2); data forwardable from M if 1, from W only if 2
- CNT_W, 32: perf counter width (macro only)

- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- rs_d_i  in  NUM_SRC*REG_AW  D-stage sources, source k at [k*REG_AW +: REG_AW]
- rs_e_i  in  NUM_SRC*REG_AW  E-stage sources
- rd_e_i / rd_m_i / rd_w_i  in  REG_AW each  destination in E/M/W
- we_reg_file_m_i / we_reg_file_w_i  in  1 each  register write enable in M/W
- result_src_e_0_i  in  1  E-stage instruction is a load
- pc_src_e_i  in  1  taken branch/jump in E
- dmem_req_i  in  1  M-stage memory access valid
- dmem_ready_i  in  1  data memory completes this cycle
- stall_f_o / stall_d_o / stall_e_o / stall_m_o  out  1 each  hold stage register
- flush_d_o / flush_e_o / flush_w_o  out  1 each  insert bubble into stage register
- forward_e_o  out  NUM_SRC*2  forward select per E source
- stall_cycles_o / flush_events_o / mem_wait_cycles_o  out  CNT_W each  (HAZARD_PERF_CNT_EN only)

## Operation
- Forwarding per source k (combinational): rs==0 -> FWD_RF; else rs==rd_m && we_reg_file_m_i && !(LOAD_LAT==2 && M is load) -> FWD_M; else rs==rd_w && we_reg_file_w_i -> FWD_W; else FWD_RF. M wins over W.
- Load-use hit: result_src_e_0_i && rd_e_i!=0 && rd_e_i equals any rs_d source.
- FSM states RUN, LOAD_WAIT, MEM_WAIT.
- RUN: mem-wait (dmem_req_i && !dmem_ready_i) -> assert stall_f/d/e/m, flush_w; next MEM_WAIT. Else load-use hit -> stall_f, stall_d, flush_e; next LOAD_WAIT if LOAD_LAT==2 else RUN. Else pc_src_e_i -> flush_d, flush_e.
- LOAD_WAIT: stall_f, stall_d, flush_e for one cycle; mem-wait overrides as in RUN; else next RUN.
- MEM_WAIT: same outputs as mem-wait while dmem_ready_i low; cycle dmem_ready_i high -> no mem stall, apply RUN rules combinationally, next RUN.
- Priority: mem-wait > load-use/LOAD_WAIT > redirect. Redirect suppressed while stall_e_o high; pc_src_e_i stays asserted (E held) and takes effect on release.
- Load-use and redirect cannot coincide (E holds one instruction); no arbitration needed.

## Timing
- Forward selects, stalls, flushes combinational from inputs and state; state updates on clk rising edge.
- Load-use cost: exactly LOAD_LAT bubble cycles; mem wait cost: one stall cycle per cycle dmem_ready_i low.
- Reset (rst high): state RUN; stall_* 0; flush_d/e/w 1; forward_e_o all FWD_RF; counters 0. Reset mid-MEM_WAIT or mid-LOAD_WAIT returns to RUN next edge; no residual stall.

## Configuration
- HAZARD_PERF_CNT_EN defined: three saturating CNT_W counters, reset to 0. stall_cycles_o +1 each cycle stall_f_o high; flush_events_o +1 each cycle flush_e_o high outside reset; mem_wait_cycles_o +1 each cycle stall_m_o high. Saturate at all-ones.
- Undefined: counter ports and logic absent; behaviour otherwise identical.

## Structure
- Shared package: FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10; FSM state encoding; LOAD_LAT range check constant.
- Sub-module fwd_sel: one E source vs rd_m/rd_w -> 2-bit select; generate-instantiated NUM_SRC times.

## Test plan
- rs_e=5, rd_m=5 we_m=1, rd_w=5 we_w=1 -> forward FWD_M; rd_m=0 with rs_e=0 -> FWD_RF.
- LOAD_LAT=1: load rd_e=7, rs_d[1]=7 -> one cycle stall_f/d=1, flush_e=1; next cycle consumer in E gets FWD_M.
- LOAD_LAT=2: same stimulus -> two bubble cycles; consumer in E gets FWD_W.
- dmem_req=1, dmem_ready low 3 cycles with pc_src_e=1 -> stall_f..m and flush_w high 3 cycles, flush_d/e low; cycle 4 ready -> flush_d/e=1.
- rst asserted during MEM_WAIT -> next edge RUN, stalls 0, flush_d/e/w=1 while rst high.
- NUM_SRC=3 with HAZARD_PERF_CNT_EN: rs_d[2] load-use hit -> stall; stall_cycles_o increments by 1, counter held at all-ones when CNT_W=4 after 15+ stalls.
